// File: rtl/gb_psum_bank_if.sv
// Partial-sum channel bundle between the global-buffer bank and a PEB/output collector.
// The slave modport is the bank side.
interface gb_psum_bank_if #(
  parameter int unsigned PSUM_WIDTH = 24
);
  logic                  GBPSUM_val;
  logic [PSUM_WIDTH-1:0] GBPSUM_data;
  logic                  PSUMGB_rdy;
  logic                  PSUMGB_val;
  logic [PSUM_WIDTH-1:0] PSUMGB_data;
  logic                  GBPSUM_rdy;
  logic                  DRN_val;
  logic [PSUM_WIDTH-1:0] DRN_data;
  logic                  DRN_rdy;

  modport slave (
    output GBPSUM_val, GBPSUM_data, GBPSUM_rdy, DRN_val, DRN_data,
    input  PSUMGB_rdy, PSUMGB_val, PSUMGB_data, DRN_rdy
  );

  modport master (
    input  GBPSUM_val, GBPSUM_data, GBPSUM_rdy, DRN_val, DRN_data,
    output PSUMGB_rdy, PSUMGB_val, PSUMGB_data, DRN_rdy
  );
endinterface

// File: rtl/gb_psum_bank.sv
// Global-buffer psum bank: feeds old psums to a PEB, stores returned psums over N passes, then drains.
// Optional protocol checker with sticky err_flag under `GBPSUM_PROTO_CHK_EN.
module gb_psum_bank #(
  parameter int unsigned PSUM_WIDTH = 24,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned PASS_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      next_block,
  input  logic [$clog2(DEPTH):0]    cfg_len,
  input  logic [PASS_WIDTH-1:0]     cfg_npass,
  gb_psum_bank_if.slave             bus,
`ifdef GBPSUM_PROTO_CHK_EN
  output logic                      err_flag,
`endif
  output logic                      blk_done
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = LW + PASS_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [LW-1:0]         len_q, len_d;
  logic [TW-1:0]         tot_q, tot_d;
  logic [TW-1:0]         r_q, r_d, w_q, w_d, rc_q, rc_d;
  logic [AW-1:0]         ra_q, ra_d, wa_q, wa_d;
  logic [LW-1:0]         dis_q, dis_d, dcnt_q, dcnt_d;
  logic                  rval_q, rval_d, wrdy_q, wrdy_d, dval_q, dval_d, done_q, done_d;
  logic [PSUM_WIDTH-1:0] rdata_q, rdata_d, ddata_q, ddata_d;
  logic [PSUM_WIDTH-1:0] mem [DEPTH];
  logic                  rd_hs_c, wr_hs_c, dr_hs_c, issue_c;

  function automatic logic [AW-1:0] wrap(input logic [AW-1:0] a, input logic [LW-1:0] l);
    return (LW'(a) + LW'(1) == l) ? '0 : a + AW'(1);
  endfunction

  assign rd_hs_c = rval_q && bus.PSUMGB_rdy;
  assign wr_hs_c = bus.PSUMGB_val && wrdy_q && (state_q == RUN) && !next_block;
  assign dr_hs_c = dval_q && bus.DRN_rdy;
  // An entry may be re-read only once its previous-pass write has landed: W + L > R.
  assign issue_c = (r_q < tot_q) && (({1'b0, w_q} + (TW+1)'(len_q)) > {1'b0, r_q});

  // Register array, not reset.
  always_ff @(posedge clk) begin
    if (wr_hs_c) mem[wa_q] <= bus.PSUMGB_data;
  end

  always_comb begin
    state_d = state_q;  len_d  = len_q;   tot_d   = tot_q;
    r_d     = r_q;      w_d    = w_q;     rc_d    = rc_q;
    ra_d    = ra_q;     wa_d   = wa_q;    dis_d   = dis_q;   dcnt_d = dcnt_q;
    rval_d  = rval_q;   rdata_d = rdata_q; dval_d = dval_q;  ddata_d = ddata_q;
    done_d  = 1'b0;
    case (state_q)
      RUN: begin
        if (rd_hs_c) begin
          rc_d   = rc_q + TW'(1);
          rval_d = 1'b0;
        end
        if (wr_hs_c) begin
          w_d  = w_q + TW'(1);
          wa_d = wrap(wa_q, len_q);
        end
        if (issue_c && (!rval_q || bus.PSUMGB_rdy)) begin
          rval_d  = 1'b1;
          rdata_d = (r_q < TW'(len_q)) ? '0 : mem[ra_q];
          r_d     = r_q + TW'(1);
          ra_d    = wrap(ra_q, len_q);
        end
        if (w_d == tot_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (dr_hs_c) begin
          dcnt_d = dcnt_q + LW'(1);
          dval_d = 1'b0;
        end
        if ((dis_q < len_q) && (!dval_q || bus.DRN_rdy)) begin
          dval_d  = 1'b1;
          ddata_d = mem[AW'(dis_q)];
          dis_d   = dis_q + LW'(1);
        end
        if (dr_hs_c && (dcnt_q + LW'(1) == len_q)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
    // Block restart overrides everything, from any state.
    if (next_block) begin
      len_d  = cfg_len;
      tot_d  = TW'(cfg_len) * TW'(cfg_npass);
      r_d    = '0; w_d = '0; rc_d = '0; ra_d = '0; wa_d = '0; dis_d = '0; dcnt_d = '0;
      rval_d = 1'b0; rdata_d = '0; dval_d = 1'b0; ddata_d = '0;
      if ((cfg_len == '0) || (cfg_npass == '0)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = RUN;
        done_d  = 1'b0;
      end
    end
    wrdy_d = (state_d == RUN) && (w_d < rc_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE; len_q <= '0; tot_q <= '0;
      r_q <= '0; w_q <= '0; rc_q <= '0; ra_q <= '0; wa_q <= '0; dis_q <= '0; dcnt_q <= '0;
      rval_q <= 1'b0; rdata_q <= '0; wrdy_q <= 1'b0; dval_q <= 1'b0; ddata_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d; len_q <= len_d; tot_q <= tot_d;
      r_q <= r_d; w_q <= w_d; rc_q <= rc_d; ra_q <= ra_d; wa_q <= wa_d;
      dis_q <= dis_d; dcnt_q <= dcnt_d;
      rval_q <= rval_d; rdata_q <= rdata_d; wrdy_q <= wrdy_d;
      dval_q <= dval_d; ddata_q <= ddata_d; done_q <= done_d;
    end
  end

  assign bus.GBPSUM_val  = rval_q;
  assign bus.GBPSUM_data = rdata_q;
  assign bus.GBPSUM_rdy  = wrdy_q;
  assign bus.DRN_val     = dval_q;
  assign bus.DRN_data    = ddata_q;
  assign blk_done        = done_q;

`ifdef GBPSUM_PROTO_CHK_EN
  logic                  err_q, err_d, pv_q, pv_d;
  logic [PSUM_WIDTH-1:0] pd_q, pd_d;

  // Sticky error: stray writes, write data changing under stall, drain valid dropped without handshake.
  always_comb begin
    err_d = err_q;
    pv_d  = bus.PSUMGB_val && !wrdy_q;
    pd_d  = bus.PSUMGB_data;
    if (bus.PSUMGB_val && (state_q != RUN))                        err_d = 1'b1;
    if (pv_q && bus.PSUMGB_val && (bus.PSUMGB_data != pd_q))       err_d = 1'b1;
    if (dval_q && !bus.DRN_rdy && !dval_d)                         err_d = 1'b1;
    if (next_block)                                                err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0; pv_q <= 1'b0; pd_q <= '0;
    end else begin
      err_q <= err_d; pv_q <= pv_d; pd_q <= pd_d;
    end
  end

  assign err_flag = err_q;
`endif
endmodule

// File: tb/tb_gb_psum_bank.sv
// Directed bench for gb_psum_bank: acts as PEB and output collector, checks read/write/drain streams.
module tb_gb_psum_bank;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        next_block = 1'b0;
  logic [8:0]  cfg_len = '0;
  logic [7:0]  cfg_npass = '0;
  logic        blk_done;
`ifdef GBPSUM_PROTO_CHK_EN
  logic        err_flag;
`endif
  int n_cmp = 0;
  int n_err = 0;

  gb_psum_bank_if #(.PSUM_WIDTH(24)) bus ();

  gb_psum_bank dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .next_block (next_block),
    .cfg_len    (cfg_len),
    .cfg_npass  (cfg_npass),
    .bus        (bus),
`ifdef GBPSUM_PROTO_CHK_EN
    .err_flag   (err_flag),
`endif
    .blk_done   (blk_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // mode 0: write back 10*(k+1) for the k-th read (N=1 only); mode 1: write back read+1.
  task automatic run_block(input int len, input int npass, input int mode, input int delay,
                           input bit bp, input int abort_w);
    int cyc, rc, wc, dk, tot, p, a;
    int pend_d[$];
    int pend_t[$];
    bit prdy, drdy, rhold, dhold, in_run;
    logic [23:0] rhold_d, dhold_d;
    int exp_v;
    cyc = 0; rc = 0; wc = 0; dk = 0; tot = len * npass;
    rhold = 0; dhold = 0; rhold_d = '0; dhold_d = '0;
    @(negedge clk);
    next_block = 1'b1; cfg_len = 9'(len); cfg_npass = 8'(npass);
    bus.PSUMGB_rdy = 1'b0; bus.PSUMGB_val = 1'b0; bus.DRN_rdy = 1'b0;
    @(negedge clk);
    next_block = 1'b0;
    check_eq("nb_gbval", 32'(bus.GBPSUM_val), 0);
    check_eq("nb_gbrdy", 32'(bus.GBPSUM_rdy), 0);
    check_eq("nb_drnval", 32'(bus.DRN_val), 0);
`ifdef GBPSUM_PROTO_CHK_EN
    check_eq("nb_err", 32'(err_flag), 0);
`endif
    while (dk < len && cyc < 4000) begin
      if (abort_w > 0 && wc == abort_w) begin
        bus.PSUMGB_rdy = 1'b0; bus.PSUMGB_val = 1'b0; bus.DRN_rdy = 1'b0;
        return;
      end
      prdy = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      drdy = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_run = (wc < tot);
      check_eq("gbrdy", 32'(bus.GBPSUM_rdy), 32'(in_run && (wc < rc)));
      check_eq("early_done", 32'(blk_done), 0);
      if (!in_run) check_eq("drain_gbval", 32'(bus.GBPSUM_val), 0);
      if (rhold) begin
        check_eq("rd_hold_val", 32'(bus.GBPSUM_val), 1);
        check_eq("rd_hold_data", 32'(bus.GBPSUM_data), 32'(rhold_d));
      end
      if (dhold) begin
        check_eq("drn_hold_val", 32'(bus.DRN_val), 1);
        check_eq("drn_hold_data", 32'(bus.DRN_data), 32'(dhold_d));
      end
      rhold = bus.GBPSUM_val && !prdy; rhold_d = bus.GBPSUM_data;
      dhold = bus.DRN_val && !drdy;    dhold_d = bus.DRN_data;
      bus.PSUMGB_rdy = prdy;
      bus.DRN_rdy    = drdy;
      if (bus.GBPSUM_val && prdy) begin
        p = rc / len; a = rc % len;
        exp_v = (p == 0) ? 0 : ((mode == 1) ? p : 10 * (a + 1));
        check_eq("rd_data", 32'(bus.GBPSUM_data), 32'(exp_v));
        if (rc >= len) check_eq("rd_order", 32'(wc >= rc - len + 1), 1);
        pend_d.push_back((mode == 1) ? int'(bus.GBPSUM_data) + 1 : 10 * (rc + 1));
        pend_t.push_back(cyc + delay);
        rc++;
      end
      bus.PSUMGB_val = 1'b0;
      if (pend_d.size() > 0 && pend_t[0] <= cyc) begin
        bus.PSUMGB_val  = 1'b1;
        bus.PSUMGB_data = 24'(pend_d[0]);
        if (bus.GBPSUM_rdy) begin
          void'(pend_d.pop_front());
          void'(pend_t.pop_front());
          wc++;
        end
      end
      if (bus.DRN_val && drdy) begin
        exp_v = (mode == 1) ? npass : 10 * (dk + 1);
        check_eq("drn_data", 32'(bus.DRN_data), 32'(exp_v));
        dk++;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 4000) check_eq("timeout", 0, 1);
    bus.PSUMGB_val = 1'b0; bus.DRN_rdy = 1'b0; bus.PSUMGB_rdy = 1'b0;
    check_eq("blk_done", 32'(blk_done), 1);
    @(negedge clk);
    check_eq("blk_done_pulse", 32'(blk_done), 0);
    check_eq("idle_drnval", 32'(bus.DRN_val), 0);
    check_eq("idle_gbval", 32'(bus.GBPSUM_val), 0);
  endtask

  initial begin
    bus.PSUMGB_rdy = 1'b0; bus.PSUMGB_val = 1'b0; bus.PSUMGB_data = '0; bus.DRN_rdy = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_gbval", 32'(bus.GBPSUM_val), 0);
    check_eq("rst_gbrdy", 32'(bus.GBPSUM_rdy), 0);
    check_eq("rst_drnval", 32'(bus.DRN_val), 0);
    check_eq("rst_done", 32'(blk_done), 0);
    rst_n = 1'b1;
    @(negedge clk);
`ifdef GBPSUM_PROTO_CHK_EN
    check_eq("rst_err", 32'(err_flag), 0);
    bus.PSUMGB_val = 1'b1; bus.PSUMGB_data = 24'd999;
    @(negedge clk);
    bus.PSUMGB_val = 1'b0;
    @(negedge clk);
    check_eq("idle_wr_err", 32'(err_flag), 1);
`endif
    run_block(4, 1, 0, 1, 1'b0, 0);
    run_block(3, 3, 1, 1, 1'b0, 0);
    run_block(2, 2, 1, 5, 1'b0, 0);
    run_block(1, 1, 0, 1, 1'b0, 0);
    run_block(16, 4, 1, 2, 1'b1, 0);
    // Abort mid-RUN after 5 writes, then restart with a fresh block.
    run_block(16, 4, 1, 1, 1'b0, 5);
    run_block(4, 2, 1, 1, 1'b0, 0);
    // Zero length goes straight back to IDLE with a done pulse.
    @(negedge clk);
    next_block = 1'b1; cfg_len = 9'd0; cfg_npass = 8'd2;
    @(negedge clk);
    next_block = 1'b0;
    check_eq("zero_len_done", 32'(blk_done), 1);
    check_eq("zero_len_gbval", 32'(bus.GBPSUM_val), 0);
    @(negedge clk);
    check_eq("zero_len_pulse", 32'(blk_done), 0);
    check_eq("zero_len_gbrdy", 32'(bus.GBPSUM_rdy), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
